tlc_chain_driver: RTL and testbench

Parametrised serial driver for one or more daisy-chained TLC6C5912 LED sink drivers. Accepts a full chain frame over a valid/ready handshake, shifts it out on SR_Q/SR_CK at a divided bit rate, then pulses SR_LATCH to transfer it to the outputs. It also drives the active-low output enable SR_G_B, holding the LEDs dark until the first frame is latched. It sits between the SOC's colour/frame logic and the PMOD pins.

---
 rtl/tlc_chain_if.sv | 27 ++
 rtl/tlc_chain_driver.sv | 168 ++++++++++++++++
 tb/tb_tlc_chain_driver.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlc_chain_if.sv
// Frame handshake bundle between the frame logic (master) and the
// TLC6C5912 chain driver (slave). TOTAL is the full chain width.
interface tlc_chain_if #(
  parameter int TOTAL = 12
);
  logic [TOTAL-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic [7:0]       brightness;

  modport master (
    output data_in,
    output data_valid,
    output brightness,
    input  data_ready,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  brightness,
    output data_ready,
    output busy
  );
endinterface

// File: rtl/tlc_chain_driver.sv
// Serial driver for a daisy chain of TLC6C5912 LED sinks.
// Accepts a frame, shifts it out on SR_Q/SR_CK at a divided rate, pulses
// SR_LATCH, and keeps SR_G_B high (LEDs dark) until the first latch.
// Optional global PWM dimming on SR_G_B is built when TLC_PWM_EN is defined.
module tlc_chain_driver #(
  parameter int NBITS     = 12,
  parameter int NDEV      = 1,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  tlc_chain_if.slave  bus,
  output logic        SR_CK,
  output logic        SR_Q,
  output logic        SR_LATCH,
  output logic        SR_G_B
);
  localparam int TOTAL = NBITS * NDEV;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [TOTAL-1:0] shreg_q, shreg_d;
  logic [TOTAL-1:0] shifted;
  logic             sr_ck_q, sr_ck_d;
  logic             sr_q_q, sr_q_d;
  logic             sr_latch_q, sr_latch_d;
  logic             sr_g_b_q, sr_g_b_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             latched_once_q, latched_once_d;

`ifdef TLC_PWM_EN
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       brightness_q, brightness_d;
`else
  logic             unused_brightness;
  assign unused_brightness = ^bus.brightness;
`endif

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    shreg_d        = shreg_q;
    sr_ck_d        = sr_ck_q;
    sr_q_d         = sr_q_q;
    sr_latch_d     = sr_latch_q;
    ready_d        = ready_q;
    latched_once_d = latched_once_q;
    shifted        = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.data_valid) begin
          shreg_d = bus.data_in;
          sr_q_d  = (MSB_FIRST != 0) ? bus.data_in[TOTAL-1] : bus.data_in[0];
          div_d   = '0;
          bit_d   = '0;
          sr_ck_d = 1'b0;
          ready_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sr_ck_q) begin
            sr_ck_d = 1'b1;
          end else begin
            // Falling SR_CK: either advance to the next bit or finish.
            sr_ck_d = 1'b0;
            if (bit_q == BW'(TOTAL - 1)) begin
              sr_q_d     = 1'b0;
              sr_latch_d = 1'b1;
              state_d    = ST_LATCH;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shifted;
              sr_q_d  = (MSB_FIRST != 0) ? shifted[TOTAL-1] : shifted[0];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d          = '0;
          sr_latch_d     = 1'b0;
          ready_d        = 1'b1;
          latched_once_d = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        sr_ck_d    = 1'b0;
        sr_q_d     = 1'b0;
        sr_latch_d = 1'b0;
        ready_d    = 1'b1;
      end
    endcase

    busy_d = !ready_d;

`ifdef TLC_PWM_EN
    pwm_cnt_d    = pwm_cnt_q + 8'd1;
    brightness_d = (pwm_cnt_q == 8'hFF) ? bus.brightness : brightness_q;
    sr_g_b_d     = latched_once_d ? !(pwm_cnt_d < brightness_d) : 1'b1;
`else
    sr_g_b_d     = !latched_once_d;
`endif
  end

  // State and output registers; reset forces the pins to their safe values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      bit_q          <= '0;
      shreg_q        <= '0;
      sr_ck_q        <= 1'b0;
      sr_q_q         <= 1'b0;
      sr_latch_q     <= 1'b0;
      sr_g_b_q       <= 1'b1;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      latched_once_q <= 1'b0;
`ifdef TLC_PWM_EN
      pwm_cnt_q      <= 8'd0;
      brightness_q   <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      sr_ck_q        <= sr_ck_d;
      sr_q_q         <= sr_q_d;
      sr_latch_q     <= sr_latch_d;
      sr_g_b_q       <= sr_g_b_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      latched_once_q <= latched_once_d;
`ifdef TLC_PWM_EN
      pwm_cnt_q      <= pwm_cnt_d;
      brightness_q   <= brightness_d;
`endif
    end
  end

  assign SR_CK          = sr_ck_q;
  assign SR_Q           = sr_q_q;
  assign SR_LATCH       = sr_latch_q;
  assign SR_G_B         = sr_g_b_q;
  assign bus.data_ready = ready_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_tlc_chain_driver.sv
// Bench for tlc_chain_driver: a default 12-bit MSB-first instance and a
// 3-device LSB-first CLK_DIV=1 instance. Expected serial bits are queued when
// a frame is offered and popped on every SR_CK rising edge.
module tb_tlc_chain_driver;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic ck_a, sq_a, la_a, gb_a;
  logic ck_b, sq_b, la_b, gb_b;
  int   checks = 0;
  int   failures = 0;
  logic qa[$];
  logic qb[$];

  tlc_chain_if #(.TOTAL(12)) ifa ();
  tlc_chain_if #(.TOTAL(36)) ifb ();

  tlc_chain_driver dut_a (
    .CLK(clk), .RESET(rst_a), .bus(ifa.slave),
    .SR_CK(ck_a), .SR_Q(sq_a), .SR_LATCH(la_a), .SR_G_B(gb_a)
  );

  tlc_chain_driver #(.NBITS(12), .NDEV(3), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .CLK(clk), .RESET(rst_b), .bus(ifb.slave),
    .SR_CK(ck_b), .SR_Q(sq_b), .SR_LATCH(la_b), .SR_G_B(gb_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [11:0] f);
    for (int i = 11; i >= 0; i--) qa.push_back(f[i]);
  endtask

  task automatic push_b(input logic [35:0] f);
    for (int i = 0; i < 36; i++) qb.push_back(f[i]);
  endtask

  // Scoreboard for instance A: each SR_CK rise consumes one expected bit.
  always @(posedge ck_a) begin
    logic e;
    checks++;
    assert (qa.size() != 0) else begin
      failures++;
      $error("FAIL a_unexpected_edge observed=%0b expected=none", sq_a);
    end
    if (qa.size() != 0) begin
      e = qa.pop_front();
      check("a_bit", sq_a, e);
      $display("A bit sampled=%0b expected=%0b", sq_a, e);
    end
  end

  // Scoreboard for instance B.
  always @(posedge ck_b) begin
    logic e;
    checks++;
    assert (qb.size() != 0) else begin
      failures++;
      $error("FAIL b_unexpected_edge observed=%0b expected=none", sq_b);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      check("b_bit", sq_b, e);
    end
  end

  initial begin
    logic ca [0:60];
    logic lat [0:60];
    logic rdy [0:60];
    logic gbs [0:60];
    logic bsy [0:60];
    int   first_rise, rises, first_lat, lats, lows, n, glow;
    logic prev, ok;

    ifa.data_in = '0; ifa.data_valid = 1'b0; ifa.brightness = 8'd0;
    ifb.data_in = '0; ifb.data_valid = 1'b0; ifb.brightness = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ck", ck_a, 1'b0);
    check("rst_q", sq_a, 1'b0);
    check("rst_latch", la_a, 1'b0);
    check("rst_gb", gb_a, 1'b1);
    check("rst_ready", ifa.data_ready, 1'b1);
    check("rst_busy", ifa.busy, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 12'hE2A with data_in corrupted during SHIFT
    push_a(12'hE2A);
    ifa.data_in = 12'hE2A; ifa.data_valid = 1'b1;
    ca[0] = ck_a;
    @(posedge clk); #1 ifa.data_valid = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      ca[k] = ck_a; lat[k] = la_a; rdy[k] = ifa.data_ready; gbs[k] = gb_a; bsy[k] = ifa.busy;
      if (k == 10) ifa.data_in = 12'h000;
    end
    first_rise = 0; rises = 0; first_lat = 0; lats = 0; lows = 0;
    for (int k = 1; k <= 52; k++) begin
      if (ca[k] && !ca[k-1]) begin rises++; if (first_rise == 0) first_rise = k; end
      if (lat[k]) begin lats++; if (first_lat == 0) first_lat = k; end
      if (!rdy[k]) lows++;
    end
    $display("frame E2A rises=%0d first_rise=%0d latch_start=%0d latch_len=%0d busy_len=%0d",
             rises, first_rise, first_lat, lats, lows);
    check("t1_first_rise", first_rise, 3);
    check("t1_rises", rises, 12);
    check("t1_latch_start", first_lat, 49);
    check("t1_latch_len", lats, 2);
    check("t1_busy_len", lows, 50);
    check("t1_ready_back", rdy[51], 1'b1);
    check("t1_busy_mid", bsy[20], 1'b1);
    check("t1_gb_before", gbs[50], 1'b1);
`ifdef TLC_PWM_EN
    check("t1_gb_after", gbs[51], 1'b1);
`else
    check("t1_gb_after", gbs[51], 1'b0);
`endif

    // Back-to-back frames with data_valid held high
    push_a(12'h5C3); push_a(12'h0F1);
    ifa.data_in = 12'h5C3; ifa.data_valid = 1'b1;
    @(posedge clk); #1 ifa.data_in = 12'h0F1;
    n = 0; ok = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (ifa.data_ready) begin ok = 1'b1; break; end
      n++;
    end
    check("b2b_first_done", ok, 1'b1);
    check("b2b_busy_len", n, 50);
    @(posedge clk); #1 ifa.data_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_idle", ifa.data_ready, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (ifa.data_ready) begin ok = 1'b1; break; end
    end
    check("b2b_second_done", ok, 1'b1);
    @(negedge clk);
    check("b2b_queue_empty", qa.size(), 0);

    // Output enable after latching
`ifdef TLC_PWM_EN
    ifa.brightness = 8'd64;
    repeat (300) @(negedge clk);
    glow = 0;
    for (int k = 0; k < 256; k++) begin @(negedge clk); if (!gb_a) glow++; end
    $display("pwm brightness=64 low_cycles=%0d", glow);
    check("pwm_duty_64", glow, 64);
`else
    ifa.brightness = 8'hFF;
    glow = 0;
    for (int k = 0; k < 300; k++) begin @(negedge clk); if (!gb_a) glow++; end
    check("gb_on_bright_ff", glow, 300);
    ifa.brightness = 8'd0;
    glow = 0;
    for (int k = 0; k < 300; k++) begin @(negedge clk); if (!gb_a) glow++; end
    check("gb_on_bright_00", glow, 300);
`endif

    // Reset at the 5th SR_CK rise
    push_a(12'hFFF);
    ifa.data_in = 12'hFFF; ifa.data_valid = 1'b1;
    @(posedge clk); #1 ifa.data_valid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ck_a && !prev) rises++;
      prev = ck_a;
      if (rises == 5) break;
    end
    check("rst_mid_reached", rises, 5);
    #2 rst_a = 1'b0;
    #1;
    check("rst_mid_ck", ck_a, 1'b0);
    check("rst_mid_q", sq_a, 1'b0);
    check("rst_mid_latch", la_a, 1'b0);
    check("rst_mid_gb", gb_a, 1'b1);
    check("rst_mid_ready", ifa.data_ready, 1'b1);
    qa.delete();
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    lats = 0; lows = 0; glow = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (la_a) lats++;
      if (!ifa.data_ready) lows++;
      if (!gb_a) glow++;
    end
    check("rst_post_latch", lats, 0);
    check("rst_post_ready_low", lows, 0);
    check("rst_post_gb_low", glow, 0);

    // Instance B: 36-bit LSB-first chain at CLK_DIV=1
    push_b(36'h0_0000_0001);
    ifb.data_in = 36'h0_0000_0001; ifb.data_valid = 1'b1;
    @(posedge clk); #1 ifb.data_valid = 1'b0;
    rises = 0; lats = 0; prev = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ck_b && !prev) rises++;
      prev = ck_b;
      if (la_b) lats++;
    end
    $display("frame B rises=%0d latch_len=%0d", rises, lats);
    check("b_rises", rises, 36);
    check("b_latch_len", lats, 1);
    check("b_ready_back", ifb.data_ready, 1'b1);
    check("b_queue_empty", qb.size(), 0);
`ifdef TLC_PWM_EN
    check("b_gb_after", gb_b, 1'b1);
`else
    check("b_gb_after", gb_b, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
